// File: rtl/bf_lane_array_pipe_if.sv
// Streaming handshake bundle for bf_lane_array_pipe: input beat (a/b/w + mode) and result beat.
// Lane i occupies element [i] of each packed vector, i.e. bits [i*DATA_W +: DATA_W].
interface bf_lane_array_pipe_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 256
);
    logic                              in_valid;
    logic                              in_ready;
    logic [1:0]                        in_mode;
    logic [NUM_LANES-1:0][DATA_W-1:0]  in_a;
    logic [NUM_LANES-1:0][DATA_W-1:0]  in_b;
    logic [NUM_LANES-1:0][DATA_W-1:0]  in_w;
    logic                              out_valid;
    logic                              out_ready;
    logic [1:0]                        out_mode;
    logic [NUM_LANES-1:0][DATA_W-1:0]  out_a;
    logic [NUM_LANES-1:0][DATA_W-1:0]  out_b;
    logic                              busy;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_w, out_ready,
        input  in_ready, out_valid, out_mode, out_a, out_b, busy
    );
    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_w, out_ready,
        output in_ready, out_valid, out_mode, out_a, out_b, busy
    );
endinterface

// File: rtl/bf_lane_array_pipe.sv
// NUM_LANES modular butterflies (CT / GS / PMUL / BYPASS) in a fixed MUL_LAT+2 stage pipeline with global stall.
// Optional: define BF_INTT_HALVE_EN to halve both GS results mod M in the final stage.
module bf_lane #(
    parameter int                DATA_W  = 256,
    parameter logic [DATA_W-1:0] M       = '1,
    parameter int                MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              ld_out,
    input  logic [1:0]        mode_s0,
    input  logic [1:0]        mode_fin,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_w,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b
);
    localparam logic [1:0] MD_CT = 2'd0, MD_GS = 2'd1, MD_PMUL = 2'd2;
    localparam logic [DATA_W:0]     M1 = {1'b0, M};
    localparam logic [2*DATA_W-1:0] M2 = {{DATA_W{1'b0}}, M};

    function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        logic [DATA_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= M1) s = s - M1;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        logic [DATA_W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[DATA_W]) d = d + M1;
        return d[DATA_W-1:0];
    endfunction

`ifdef BF_INTT_HALVE_EN
    // x/2 mod M: odd values borrow one M so the shift is exact (M is odd)
    function automatic logic [DATA_W-1:0] halve(input logic [DATA_W-1:0] x);
        return x[0] ? DATA_W'(({1'b0, x} + M1) >> 1) : (x >> 1);
    endfunction
`endif

    logic [DATA_W-1:0] a0_q, a0_d, b0_q, b0_d, w0_q, w0_d, sum0_q, sum0_d, dif0_q, dif0_d;
    logic [DATA_W-1:0] mx, side_a;
    logic [2*DATA_W-1:0] prod;
    logic [MUL_LAT:1][DATA_W-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [DATA_W-1:0] red_q, red_d;
    logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;

    always_comb begin
        a0_d   = a0_q;
        b0_d   = b0_q;
        w0_d   = w0_q;
        sum0_d = sum0_q;
        dif0_d = dif0_q;
        if (adv) begin
            a0_d   = in_a;
            b0_d   = in_b;
            w0_d   = in_w;
            sum0_d = add_mod(in_a, in_b);
            dif0_d = sub_mod(in_a, in_b);
        end
    end

    // GS multiplies the difference and forwards the sum; the other modes use b and a
    assign mx     = (mode_s0 == MD_GS) ? dif0_q : b0_q;
    assign side_a = (mode_s0 == MD_GS) ? sum0_q : a0_q;
    assign prod   = {{DATA_W{1'b0}}, mx} * {{DATA_W{1'b0}}, w0_q};

    always_comb begin
        sa_d = sa_q;
        sb_d = sb_q;
        if (adv) begin
            sa_d[1] = side_a;
            sb_d[1] = b0_q;
            for (int k = 2; k <= MUL_LAT; k++) begin
                sa_d[k] = sa_q[k-1];
                sb_d[k] = sb_q[k-1];
            end
        end
    end

    generate
        if (MUL_LAT == 1) begin : g_mul1
            always_comb red_d = adv ? DATA_W'(prod % M2) : red_q;
        end else begin : g_muln
            logic [MUL_LAT-1:1][2*DATA_W-1:0] pp_q, pp_d;
            always_comb begin
                pp_d  = pp_q;
                red_d = red_q;
                if (adv) begin
                    pp_d[1] = prod;
                    for (int k = 2; k <= MUL_LAT-1; k++) pp_d[k] = pp_q[k-1];
                    red_d = DATA_W'(pp_q[MUL_LAT-1] % M2);
                end
            end
            always_ff @(posedge clk) pp_q <= pp_d;
        end
    endgenerate

    always_comb begin
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        if (ld_out) begin
            case (mode_fin)
                MD_CT: begin
                    out_a_d = add_mod(sa_q[MUL_LAT], red_q);
                    out_b_d = sub_mod(sa_q[MUL_LAT], red_q);
                end
                MD_GS: begin
`ifdef BF_INTT_HALVE_EN
                    out_a_d = halve(sa_q[MUL_LAT]);
                    out_b_d = halve(red_q);
`else
                    out_a_d = sa_q[MUL_LAT];
                    out_b_d = red_q;
`endif
                end
                MD_PMUL: begin
                    out_a_d = red_q;
                    out_b_d = '0;
                end
                default: begin
                    out_a_d = sa_q[MUL_LAT];
                    out_b_d = sb_q[MUL_LAT];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        a0_q   <= a0_d;
        b0_q   <= b0_d;
        w0_q   <= w0_d;
        sum0_q <= sum0_d;
        dif0_q <= dif0_d;
        sa_q   <= sa_d;
        sb_q   <= sb_d;
        red_q  <= red_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    assign out_a = out_a_q;
    assign out_b = out_b_q;
endmodule

module bf_lane_array_pipe #(
    parameter int                NUM_LANES = 4,
    parameter int                DATA_W    = 256,
    parameter logic [DATA_W-1:0] M         = 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001,
    parameter int                MUL_LAT   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bf_lane_array_pipe_if.slave bus
);
    // vld_pipe[0] = input reg, [1..MUL_LAT] = multiplier stages, [STAGES] = output reg
    localparam int STAGES = MUL_LAT + 1;

    logic [STAGES:0]           vld_pipe_q, vld_pipe_d;
    logic [MUL_LAT:0][1:0]     mode_q, mode_d;
    logic [1:0]                out_mode_q, out_mode_d;
    logic                      adv, ld_out;
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_a, lane_b;

    assign adv    = ~vld_pipe_q[STAGES] | bus.out_ready;
    assign ld_out = adv & vld_pipe_q[STAGES-1];

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        mode_d     = mode_q;
        out_mode_d = out_mode_q;
        if (adv) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:0], bus.in_valid};
            mode_d     = {mode_q[MUL_LAT-1:0], bus.in_mode};
        end
        if (ld_out) out_mode_d = mode_q[MUL_LAT];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            out_mode_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            out_mode_q <= out_mode_d;
        end
    end

    always_ff @(posedge clk) mode_q <= mode_d;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            bf_lane #(.DATA_W(DATA_W), .M(M), .MUL_LAT(MUL_LAT)) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .adv      (adv),
                .ld_out   (ld_out),
                .mode_s0  (mode_q[0]),
                .mode_fin (mode_q[MUL_LAT]),
                .in_a     (bus.in_a[i]),
                .in_b     (bus.in_b[i]),
                .in_w     (bus.in_w[i]),
                .out_a    (lane_a[i]),
                .out_b    (lane_b[i])
            );
        end
    endgenerate

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe_q[STAGES];
    assign bus.out_mode  = out_mode_q;
    assign bus.out_a     = lane_a;
    assign bus.out_b     = lane_b;
    assign bus.busy      = |vld_pipe_q;
endmodule

// File: tb/tb_bf_lane_array_pipe.sv
// Bench for bf_lane_array_pipe: 2 lanes, 8-bit data, M=17, MUL_LAT=2 (latency 4), against a queue-based model.
module tb_bf_lane_array_pipe;
    localparam int NL = 2, W = 8, MI = 17, ML = 2;
    typedef logic [NL-1:0][W-1:0] vec_t;
    typedef struct packed { logic [1:0] mode; vec_t a; vec_t b; } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bf_lane_array_pipe_if #(.NUM_LANES(NL), .DATA_W(W)) bus ();
    bf_lane_array_pipe #(.NUM_LANES(NL), .DATA_W(W), .M(8'd17), .MUL_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    int    tests = 0, fails = 0, n_out = 0;
    beat_t q[$];
    logic  prev_stall = 1'b0;
    beat_t prev_o;

    function automatic int hv(input int x);
`ifdef BF_INTT_HALVE_EN
        return (x % 2 == 0) ? x / 2 : (x + MI) / 2;
`else
        return x;
`endif
    endfunction

    function automatic beat_t model(input logic [1:0] md, input vec_t a, input vec_t b, input vec_t w);
        beat_t r;
        int x, y, z, t, u;
        r.mode = md;
        for (int i = 0; i < NL; i++) begin
            x = int'(a[i]); y = int'(b[i]); z = int'(w[i]);
            case (md)
                2'd0: begin t = (z * y) % MI; r.a[i] = W'((x + t) % MI); r.b[i] = W'((x - t + MI) % MI); end
                2'd1: begin
                    t = hv((x + y) % MI);
                    u = hv((((x - y + MI) % MI) * z) % MI);
                    r.a[i] = W'(t); r.b[i] = W'(u);
                end
                2'd2: begin r.a[i] = W'((y * z) % MI); r.b[i] = '0; end
                default: begin r.a[i] = a[i]; r.b[i] = b[i]; end
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] md, input vec_t a, input vec_t b, input vec_t w);
        bus.in_valid = 1'b1; bus.in_mode = md; bus.in_a = a; bus.in_b = b; bus.in_w = w;
    endtask

    task automatic send_rand(input logic [1:0] md);
        vec_t a, b, w;
        for (int i = 0; i < NL; i++) begin
            a[i] = W'($urandom_range(0, MI - 1));
            b[i] = W'($urandom_range(0, MI - 1));
            w[i] = W'($urandom_range(0, MI - 1));
        end
        send(md, a, b, w);
    endtask

    task automatic directed(input string nm, input logic [1:0] md, input vec_t a, input vec_t b, input vec_t w,
                            input int ea0, input int eb0, input int ea1, input int eb1);
        send(md, a, b, w);
        step();
        bus.in_valid = 1'b0;
        step(); step();
        chk({nm, " early valid"}, int'(bus.out_valid), 0);
        step();
        chk({nm, " valid"}, int'(bus.out_valid), 1);
        chk({nm, " mode"}, int'(bus.out_mode), int'(md));
        chk({nm, " a0"}, int'(bus.out_a[0]), ea0);
        chk({nm, " b0"}, int'(bus.out_b[0]), eb0);
        chk({nm, " a1"}, int'(bus.out_a[1]), ea1);
        chk({nm, " b1"}, int'(bus.out_b[1]), eb1);
        step();
    endtask

    // Scoreboard: decisions at negedge refer to the upcoming posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("busy vs occupancy", int'(bus.busy), int'(q.size() != 0));
            chk("in_ready rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
            if (prev_stall) begin
                tests++;
                if (!bus.out_valid || {bus.out_mode, bus.out_a, bus.out_b} !== prev_o) begin
                    fails++;
                    $display("FAIL stall hold: got v=%0b %h expected v=1 %h", bus.out_valid,
                             {bus.out_mode, bus.out_a, bus.out_b}, prev_o);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                beat_t e;
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious beat: got %h expected none", {bus.out_mode, bus.out_a, bus.out_b});
                end else begin
                    e = q.pop_front();
                    if ({bus.out_mode, bus.out_a, bus.out_b} !== e) begin
                        fails++;
                        $display("FAIL result beat: got %h expected %h", {bus.out_mode, bus.out_a, bus.out_b}, e);
                    end
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_mode, bus.in_a, bus.in_b, bus.in_w));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_o     = {bus.out_mode, bus.out_a, bus.out_b};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t  va, vb, vw;
        beat_t r;
        int    n0, sent, stale;
        bus.in_valid = 1'b0; bus.in_mode = '0; bus.in_a = '0; bus.in_b = '0; bus.in_w = '0;
        bus.out_ready = 1'b1;

        // Pin the model to hand-computed values
        va[0] = 8'd3;  vb[0] = 8'd5;  vw[0] = 8'd4;
        va[1] = 8'd16; vb[1] = 8'd16; vw[1] = 8'd16;
        r = model(2'd0, va, vb, vw);
        chk("model ct a0", int'(r.a[0]), 6);  chk("model ct b0", int'(r.b[0]), 0);
        chk("model ct a1", int'(r.a[1]), 0);  chk("model ct b1", int'(r.b[1]), 15);
        r = model(2'd1, va, vb, vw);
`ifdef BF_INTT_HALVE_EN
        chk("model gs a0", int'(r.a[0]), 4);  chk("model gs b0", int'(r.b[0]), 13);
`else
        chk("model gs a0", int'(r.a[0]), 8);  chk("model gs b0", int'(r.b[0]), 9);
`endif

        repeat (3) step();
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset out_a", int'(bus.out_a), 0);
        chk("reset out_b", int'(bus.out_b), 0);
        chk("reset out_mode", int'(bus.out_mode), 0);
        chk("reset in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;
        step();

        directed("ct", 2'd0, va, vb, vw, 6, 0, 0, 15);
`ifdef BF_INTT_HALVE_EN
        directed("gs", 2'd1, va, vb, vw, 4, 13, 16, 0);
`else
        directed("gs", 2'd1, va, vb, vw, 8, 9, 15, 0);
`endif
        va[0] = 8'd7; vb[0] = 8'd9; vw[0] = 8'd2;
        directed("pmul", 2'd2, va, vb, vw, 1, 0, 1, 0);
        va[0] = 8'd11; vb[0] = 8'd12;
        directed("bypass", 2'd3, va, vb, vw, 11, 12, 16, 16);

        // 10-beat stream with downstream stalled in cycles 3..7
        n0 = n_out; sent = 0;
        for (int c = 0; c < 60 && (sent < 10 || q.size() != 0); c++) begin
            bus.out_ready = !(c >= 3 && c <= 7);
            if (sent < 10) send_rand(2'($urandom_range(0, 3)));
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            if (c >= 4 && c <= 7) chk("stream in_ready stalled", int'(bus.in_ready), 0);
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("stream count", n_out - n0, 10);
        chk("stream drained", q.size(), 0);

        // CT/GS alternating at full rate
        n0 = n_out;
        for (int c = 0; c < 24; c++) begin
            if (c < 20) send_rand(2'(c % 2));
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (c < 20) chk("alt in_ready", int'(bus.in_ready), 1);
            step();
        end
        chk("alt throughput", n_out - n0, 20);

        // Random traffic and backpressure
        for (int c = 0; c < 300; c++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) != 0) send_rand(2'($urandom_range(0, 3)));
            else bus.in_valid = 1'b0;
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) step();
        chk("random drained", q.size(), 0);

        // Reset with 3 beats in flight and the output stalled
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            send_rand(2'($urandom_range(0, 3)));
            step();
        end
        bus.in_valid = 1'b0;
        step(); step();
        chk("stall out_valid", int'(bus.out_valid), 1);
        chk("stall busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        step();
        chk("midrst out_valid", int'(bus.out_valid), 0);
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst out_a", int'(bus.out_a), 0);
        chk("midrst out_b", int'(bus.out_b), 0);
        chk("midrst in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1; bus.out_ready = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
            step();
        end
        chk("no stale beat", stale, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
